// File: rtl/memory_pkg.sv
// Shared types for the memory port arbiter and related sequencing blocks.
package memory_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } arbiter_state_t;

  typedef enum logic {
    LOAD  = 1'b0,
    STORE = 1'b1
  } access_kind_t;

  typedef enum logic {
    OUTCOME_DONE  = 1'b0,
    OUTCOME_ERROR = 1'b1
  } outcome_t;

  // Width of a counter that must hold 0..timeout-1; at least one bit so a
  // disabled timeout (0) still yields a legal vector.
  function automatic int timer_width(input int timeout);
    return (timeout > 0) ? $clog2(timeout + 1) : 1;
  endfunction

endpackage

// File: rtl/round_robin_picker.sv
// Combinational round-robin search: first asserted request at or after the
// pointer, wrapping modulo WAYS.
module round_robin_picker #(
  parameter int WAYS = 2
) (
  input  logic [WAYS-1:0]         request_in,
  input  logic [$clog2(WAYS)-1:0] pointer_in,
  output logic                    found_out,
  output logic [$clog2(WAYS)-1:0] index_out
);

  localparam int IW = $clog2(WAYS);

  // One spare bit so pointer + offset cannot overflow before the wrap.
  logic [IW:0] cand;

  // Scan offsets from the far end down so the nearest hit is the last write.
  always_comb begin
    found_out = 1'b0;
    index_out = '0;
    cand      = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      cand = {1'b0, pointer_in} + (IW+1)'(i);
      if (cand >= (IW+1)'(WAYS)) cand = cand - (IW+1)'(WAYS);
      if (request_in[cand[IW-1:0]]) begin
        found_out = 1'b1;
        index_out = cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Shared memory port sequencer: round-robin grant, steady load/store strobe
// while busy, one-cycle done/error pulse to the grantee, then one idle cycle.
module memory_arbiter
  import memory_pkg::*;
#(
  parameter int WAYS    = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                    clockIn,
  input  logic                    resetIn,
  input  logic [WAYS-1:0]         requestBitsIn,
  input  logic [WAYS-1:0]         storeBitsIn,
  output logic [WAYS-1:0]         grantBitsOut,
  output logic [$clog2(WAYS)-1:0] grantIndexOut,
  output logic [WAYS-1:0]         doneBitsOut,
  output logic [WAYS-1:0]         errorBitsOut,
  output logic                    loadOut,
  output logic                    storeOut,
  input  logic                    readyIn
);

  localparam int IW = $clog2(WAYS);
  localparam int TW = timer_width(TIMEOUT);
  localparam logic [TW-1:0] TIMER_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [TW-1:0] TIMER_MAX  = '1;

  arbiter_state_t state_q, state_d;
  logic [IW-1:0]  pointer_q, pointer_d;
  logic [IW-1:0]  grant_index_q, grant_index_d;
  logic [TW-1:0]  timer_q, timer_d;
  access_kind_t   kind_q, kind_d;
  outcome_t       outcome_q, outcome_d;

  logic           pick_found;
  logic [IW-1:0]  pick_index;

  round_robin_picker #(.WAYS(WAYS)) u_picker (
    .request_in (requestBitsIn),
    .pointer_in (pointer_q),
    .found_out  (pick_found),
    .index_out  (pick_index)
  );

  // State, fairness pointer, grantee and busy timer; reset abandons any access.
  always_ff @(posedge clockIn or negedge resetIn) begin
    if (!resetIn) begin
      state_q       <= IDLE;
      pointer_q     <= '0;
      grant_index_q <= '0;
      timer_q       <= '0;
      kind_q        <= LOAD;
      outcome_q     <= OUTCOME_DONE;
    end else begin
      state_q       <= state_d;
      pointer_q     <= pointer_d;
      grant_index_q <= grant_index_d;
      timer_q       <= timer_d;
      kind_q        <= kind_d;
      outcome_q     <= outcome_d;
    end
  end

  // Next-state: arbitrate in IDLE, wait for ready or timeout in BUSY,
  // RELEASE always falls back to IDLE so a held request is re-arbitrated.
  always_comb begin
    state_d       = state_q;
    pointer_d     = pointer_q;
    grant_index_d = grant_index_q;
    timer_d       = timer_q;
    kind_d        = kind_q;
    outcome_d     = outcome_q;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d       = BUSY;
          grant_index_d = pick_index;
          kind_d        = storeBitsIn[pick_index] ? STORE : LOAD;
          timer_d       = '0;
          pointer_d     = (pick_index == IW'(WAYS - 1)) ? '0 : pick_index + IW'(1);
        end
      end
      BUSY: begin
        // Ready is tested first so it wins over a coincident expiry.
        if (readyIn) begin
          state_d   = RELEASE;
          outcome_d = OUTCOME_DONE;
        end else if ((TIMEOUT != 0) && (timer_q == TIMER_LAST)) begin
          state_d   = RELEASE;
          outcome_d = OUTCOME_ERROR;
        end else if (timer_q != TIMER_MAX) begin
          timer_d = timer_q + TW'(1);
        end
      end
      RELEASE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decode registered state only; nothing flows from inputs.
  always_comb begin
    grantBitsOut = '0;
    doneBitsOut  = '0;
    errorBitsOut = '0;
    loadOut      = 1'b0;
    storeOut     = 1'b0;
    unique case (state_q)
      BUSY: begin
        grantBitsOut[grant_index_q] = 1'b1;
        loadOut  = (kind_q == LOAD);
        storeOut = (kind_q == STORE);
      end
      RELEASE: begin
        if (outcome_q == OUTCOME_ERROR) errorBitsOut[grant_index_q] = 1'b1;
        else                            doneBitsOut[grant_index_q]  = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign grantIndexOut = grant_index_q;

endmodule
